// File: rtl/centipede_video_pkg.sv
// Shared timing defaults and types for the Centipede raster timing block.
package centipede_video_pkg;

  localparam int DEF_H_TOTAL      = 384;
  localparam int DEF_H_ACTIVE     = 256;
  localparam int DEF_H_SYNC_START = 288;
  localparam int DEF_H_SYNC_WIDTH = 32;
  localparam int DEF_V_TOTAL      = 262;
  localparam int DEF_V_ACTIVE     = 240;
  localparam int DEF_V_SYNC_START = 246;
  localparam int DEF_V_SYNC_WIDTH = 4;
  localparam int DEF_PIPE_DLY     = 2;
  localparam int DEF_IRQ_PHASE    = 16;

  localparam int STROBE_W = 4;

  // 9-bit colour, RGB 3-3-3
  typedef logic [8:0] rgb_t;

  // Sync/blank strobe bundle carried through the alignment delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } strobes_t;

endpackage

// File: rtl/video_delay_line.sv
// Synchronous-reset shift register exposing its last tap and the tap before it.
module video_delay_line #(
  parameter int W     = 4,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] dout_prev
);

  logic [DEPTH:1][W-1:0] stage_q;
  logic [DEPTH:1][W-1:0] stage_d;
  logic [DEPTH:0][W-1:0] chain;

  // Tap k of the chain is din delayed by k cycles; tap 0 is din itself
  assign chain = {stage_q, din};

  // Shift every stage one position deeper
  always_comb begin
    stage_d = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      stage_d[k] = chain[k-1];
    end
  end

  // Stage registers clear to zero on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout      = chain[DEPTH];
  assign dout_prev = chain[DEPTH-1];

endmodule

// File: rtl/centipede_video_timing.sv
// Raster counters, sync/blank decode, renderer re-alignment, scanline irq and frame pulse.
module centipede_video_timing
  import centipede_video_pkg::*;
#(
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_WIDTH = DEF_H_SYNC_WIDTH,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_WIDTH = DEF_V_SYNC_WIDTH,
  parameter int PIPE_DLY     = DEF_PIPE_DLY,
  parameter int IRQ_PHASE    = DEF_IRQ_PHASE
) (
  input  logic       clk6m,
  input  logic       reset,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  input  logic [8:0] pix_i,
  output logic [8:0] rgb_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       hblank_o,
  output logic       vblank_o,
  output logic       irq_o,
  input  logic       irq_ack,
  output logic       frame_o
);

  // Ten-bit thresholds so that sync windows ending at 512 still compare correctly
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_SYNC_START);
  localparam logic [9:0] HS_HI  = 10'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [9:0] VS_LO  = 10'(V_SYNC_START);
  localparam logic [9:0] VS_HI  = 10'(V_SYNC_START + V_SYNC_WIDTH);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [5:0] IRQ_LN = 6'(IRQ_PHASE);

  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  rgb_t       rgb_q, rgb_d;
  logic       irq_q, irq_d;
  logic       irq_set;
  strobes_t   raw_s;
  strobes_t   out_s;
  strobes_t   blank_s;

  // hcount free-runs; vcount steps (and wraps) on the last pixel of each line
  always_comb begin
    hcount_d = hcount_q + 9'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? 9'd0 : vcount_q + 9'd1;
    end
  end

  // Raw sync/blank decode straight from the counters
  always_comb begin
    raw_s    = '0;
    raw_s.hb = ({1'b0, hcount_q} >= H_ACT);
    raw_s.vb = ({1'b0, vcount_q} >= V_ACT);
    raw_s.hs = ({1'b0, hcount_q} >= HS_LO) && ({1'b0, hcount_q} < HS_HI);
    raw_s.vs = ({1'b0, vcount_q} >= VS_LO) && ({1'b0, vcount_q} < VS_HI);
  end

  // Strobes lag the counters by the renderer latency plus the rgb register
  video_delay_line #(
    .W     (STROBE_W),
    .DEPTH (PIPE_DLY + 1)
  ) u_strobe_dly (
    .clk       (clk6m),
    .rst       (reset),
    .din       (raw_s),
    .dout      (out_s),
    .dout_prev (blank_s)
  );

  // Colour register blanks on the strobe tap that lines up with pix_i; irq set beats ack
  always_comb begin
    rgb_d   = (blank_s.hb | blank_s.vb) ? rgb_t'(0) : pix_i;
    irq_set = (hcount_q == 9'd0) && (vcount_q[5:0] == IRQ_LN) && ({1'b0, vcount_q} < V_TOT);
    irq_d   = irq_set | (irq_q & ~irq_ack);
  end

  // State registers
  always_ff @(posedge clk6m) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      rgb_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      rgb_q    <= rgb_d;
      irq_q    <= irq_d;
    end
  end

  assign hcount   = hcount_q;
  assign vcount   = vcount_q;
  assign rgb_o    = rgb_q;
  assign hsync_o  = out_s.hs;
  assign vsync_o  = out_s.vs;
  assign hblank_o = out_s.hb;
  assign vblank_o = out_s.vb;
  assign irq_o    = irq_q;
  assign frame_o  = (hcount_q == 9'd0) && ({1'b0, vcount_q} == V_ACT);

endmodule

// File: tb/tb_centipede_video_timing.sv
// Bench for centipede_video_timing: spot-check table, per-cycle reference model, pulse-width tallies.
module tb_centipede_video_timing;

  // Short lines keep two full frames compact; vertical timing and PIPE_DLY are the defaults
  localparam int H     = 96;
  localparam int HA    = 48;
  localparam int HSS   = 56;
  localparam int HSW   = 32;
  localparam int V     = 262;
  localparam int VA    = 240;
  localparam int VSS   = 246;
  localparam int VSW   = 4;
  localparam int D     = 2;
  localparam int IRQP  = 16;
  localparam int FRAME = H * V;

  logic       clk6m = 1'b0;
  logic       reset = 1'b1;
  logic       irq_ack = 1'b0;
  logic [8:0] pix_i = 9'd0;
  logic [8:0] hcount, vcount, rgb_o;
  logic       hsync_o, vsync_o, hblank_o, vblank_o, irq_o, frame_o;

  always #5 clk6m = ~clk6m;

  centipede_video_timing #(
    .H_TOTAL(H), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
    .V_TOTAL(V), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
    .PIPE_DLY(D), .IRQ_PHASE(IRQP)
  ) dut (
    .clk6m(clk6m), .reset(reset), .hcount(hcount), .vcount(vcount),
    .pix_i(pix_i), .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .hblank_o(hblank_o), .vblank_o(vblank_o), .irq_o(irq_o),
    .irq_ack(irq_ack), .frame_o(frame_o)
  );

  int         total = 0;
  int         bad = 0;
  int         n = 0;
  int         abs_n = 0;
  bit         exp_irq = 1'b0;
  logic [8:0] prev_pix = 9'd0;
  bit         measure = 1'b1;
  int         frame_at[$];
  int         hs_cnt = 0, vs_cnt = 0, hb_cnt = 0, vb_cnt = 0;
  int         first_hs = -1, first_vs = -1;
  int         blank_bad = 0;

  typedef struct {
    string      name;
    int         cyc;
    bit         ack;
    bit         chk_irq;
    logic [8:0] h;
    logic [8:0] v;
    bit         irq;
    bit         frame;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // {hs,vs,hb,vb} for the raster position reached m cycles after reset release
  function automatic logic [3:0] raw_at(input int m);
    int p, h, v;
    p = m % FRAME; h = p % H; v = p / H;
    return {1'(h >= HSS && h < HSS + HSW), 1'(v >= VSS && v < VSS + VSW),
            1'(h >= HA), 1'(v >= VA)};
  endfunction

  function automatic bit irq_line_start(input int m);
    int p, h, v;
    p = m % FRAME; h = p % H; v = p / H;
    return (h == 0) && ((v % 64) == IRQP) && (v < V);
  endfunction

  // Renderer stand-in: colour derived from the counter position of cycle m
  function automatic logic [8:0] renderer(input int m);
    int p, h, v;
    p = m % FRAME; h = p % H; v = p / H;
    return {3'(v % 8), 6'(h % 64)};
  endfunction

  task automatic compare_now();
    int p, h, v;
    logic [3:0]  es, bt;
    logic [8:0]  er;
    logic [32:0] e, a;
    p = n % FRAME; h = p % H; v = p / H;
    es = (n < D + 1) ? 4'b0 : raw_at(n - D - 1);
    er = 9'd0;
    if (n > 0) begin
      bt = (n - 1 >= D) ? raw_at(n - 1 - D) : 4'b0;
      er = (bt[1] | bt[0]) ? 9'd0 : prev_pix;
    end
    e = {9'(h), 9'(v), es, er, exp_irq, 1'(h == 0 && v == VA)};
    a = {hcount, vcount, hsync_o, vsync_o, hblank_o, vblank_o, rgb_o, irq_o, frame_o};
    check($sformatf("scoreboard n=%0d", n), 64'(a), 64'(e));
    if (frame_o) frame_at.push_back(abs_n);
    if ((hblank_o | vblank_o) && rgb_o != 9'd0) blank_bad++;
    if (measure && n >= D + 1 && n < D + 1 + FRAME) begin
      hs_cnt += int'(hsync_o);
      vs_cnt += int'(vsync_o);
      hb_cnt += int'(hblank_o);
      vb_cnt += int'(vblank_o);
      if (hsync_o && first_hs < 0) first_hs = n;
      if (vsync_o && first_vs < 0) first_vs = n;
    end
  endtask

  task automatic step(input bit ack, input bit rand_pix);
    logic [8:0] pix;
    pix = (rand_pix || n < D) ? 9'($urandom) : renderer(n - D);
    pix_i   = pix;
    irq_ack = ack;
    exp_irq = irq_line_start(n) | (exp_irq & ~ack);
    prev_pix = pix;
    @(posedge clk6m);
    #1;
    n++;
    abs_n++;
    irq_ack = 1'b0;
    compare_now();
  endtask

  function automatic bit rnd_ack();
    if (n >= FRAME + 8 && n < 2 * FRAME) return ($urandom_range(0, 63) == 0);
    return 1'b0;
  endfunction

  initial begin
    vecs[0]  = '{"reset_state",     0,     0, 1, 9'd0,  9'd0,   0, 0};
    vecs[1]  = '{"h_last",          95,    0, 1, 9'd95, 9'd0,   0, 0};
    vecs[2]  = '{"h_wrap",          96,    0, 1, 9'd0,  9'd1,   0, 0};
    vecs[3]  = '{"irq16_edge",      1536,  0, 1, 9'd0,  9'd16,  0, 0};
    vecs[4]  = '{"irq16_set",       1537,  0, 1, 9'd1,  9'd16,  1, 0};
    vecs[5]  = '{"irq_held",        1824,  0, 1, 9'd0,  9'd19,  1, 0};
    vecs[6]  = '{"ack_line20",      1920,  1, 1, 9'd0,  9'd20,  1, 0};
    vecs[7]  = '{"ack_cleared",     1921,  0, 1, 9'd1,  9'd20,  0, 0};
    vecs[8]  = '{"ack_idle",        3000,  1, 1, 9'd24, 9'd31,  0, 0};
    vecs[9]  = '{"ack_idle_after",  3001,  0, 1, 9'd25, 9'd31,  0, 0};
    vecs[10] = '{"ack_vs_set80",    7680,  1, 1, 9'd0,  9'd80,  0, 0};
    vecs[11] = '{"set_wins",        7681,  0, 1, 9'd1,  9'd80,  1, 0};
    vecs[12] = '{"pre_frame",       23039, 0, 1, 9'd95, 9'd239, 1, 0};
    vecs[13] = '{"frame_pulse",     23040, 0, 1, 9'd0,  9'd240, 1, 1};
    vecs[14] = '{"frame_one_cyc",   23041, 0, 1, 9'd1,  9'd240, 1, 0};
    vecs[15] = '{"v_last",          25151, 0, 0, 9'd95, 9'd261, 0, 0};
    vecs[16] = '{"v_wrap",          25152, 0, 0, 9'd0,  9'd0,   0, 0};
    vecs[17] = '{"frame_pulse2",    48192, 0, 0, 9'd0,  9'd240, 0, 1};

    reset = 1'b1;
    repeat (3) @(posedge clk6m);
    #1;
    reset = 1'b0;
    n = 0;
    exp_irq = 1'b0;
    compare_now();

    for (int i = 0; i < 18; i++) begin
      while (n < vecs[i].cyc) step(rnd_ack(), n >= FRAME);
      check({vecs[i].name, " hcount"}, 64'(hcount), 64'(vecs[i].h));
      check({vecs[i].name, " vcount"}, 64'(vcount), 64'(vecs[i].v));
      check({vecs[i].name, " frame_o"}, 64'(frame_o), 64'(vecs[i].frame));
      if (vecs[i].chk_irq) check({vecs[i].name, " irq_o"}, 64'(irq_o), 64'(vecs[i].irq));
      if (vecs[i].ack) step(1'b1, n >= FRAME);
    end

    while (n < 2 * FRAME) step(rnd_ack(), 1'b1);
    measure = 1'b0;

    check("frame_count", 64'(frame_at.size()), 64'd2);
    if (frame_at.size() == 2) check("frame_period", 64'(frame_at[1] - frame_at[0]), 64'(FRAME));
    check("hsync_first", 64'(first_hs), 64'(HSS + D + 1));
    check("vsync_first", 64'(first_vs), 64'(VSS * H + D + 1));
    check("hsync_cycles", 64'(hs_cnt), 64'(HSW * V));
    check("hblank_cycles", 64'(hb_cnt), 64'((H - HA) * V));
    check("vsync_cycles", 64'(vs_cnt), 64'(VSW * H));
    check("vblank_cycles", 64'(vb_cnt), 64'((V - VA) * H));

    // Third frame: let the line-80 irq pend, then reset at line 100, pixel 80
    while (n < 2 * FRAME + 100 * H + 80) step(1'b0, 1'b1);
    check("irq_pending", 64'(irq_o), 64'd1);
    check("mid_hcount_pre", 64'(hcount), 64'd80);
    check("mid_hblank_pre", 64'(hblank_o), 64'd1);
    reset = 1'b1;
    pix_i = 9'($urandom);
    @(posedge clk6m);
    #1;
    reset = 1'b0;
    n = 0;
    exp_irq = 1'b0;
    check("rst_mid hcount", 64'(hcount), 64'd0);
    check("rst_mid vcount", 64'(vcount), 64'd0);
    check("rst_mid irq_o", 64'(irq_o), 64'd0);
    check("rst_mid strobes", 64'({hsync_o, vsync_o, hblank_o, vblank_o}), 64'd0);
    check("rst_mid rgb_o", 64'(rgb_o), 64'd0);
    compare_now();
    repeat (H + 10) step(1'b0, 1'b0);
    check("rst_resume hcount", 64'(hcount), 64'd10);
    check("rst_resume vcount", 64'(vcount), 64'd1);
    check("rst_resume hblank", 64'(hblank_o), 64'd0);

    check("blank_forces_zero", 64'(blank_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/centipede_video_timing.md
# centipede_video_timing

Raster timing generator for the arcade core, running in the 6 MHz pixel domain. Produces the raw 256x240 pixel/line counters used by the playfield and motion-object renderers. Re-aligns the renderer's 9-bit pixel output with delayed sync/blank strobes and drives the `hsync_i`/`vsync_i`/`hblank_i`/`vblank_i`/`rgb_i` inputs of the scan converter. Also generates the CPU scanline interrupt and a once-per-frame vblank-start pulse.

## Interface
Parameters:
- `H_TOTAL`, 384: pixels per line.
- `H_ACTIVE`, 256: visible pixels, counts `0..H_ACTIVE-1`.
- `H_SYNC_START`, 288: first `hcount` with hsync asserted.
- `H_SYNC_WIDTH`, 32: hsync length in pixels.
- `V_TOTAL`, 262: lines per frame.
- `V_ACTIVE`, 240: visible lines.
- `V_SYNC_START`, 246: first `vcount` with vsync asserted.
- `V_SYNC_WIDTH`, 4: vsync length in lines.
- `PIPE_DLY`, 2: renderer latency in cycles, from `hcount`/`vcount` to `pix_i`. Legal range 0..7.
- `IRQ_PHASE`, 16: irq fires on lines where `vcount[5:0]==IRQ_PHASE`.

Ports:
- `clk6m` in 1: pixel clock. It is the only clock.
- `reset` in 1: synchronous, active-high.
- `hcount` out 9: raw pixel counter, to the renderers.
- `vcount` out 9: raw line counter, to the renderers.
- `pix_i` in 9: renderer colour, RGB 3-3-3. Valid `PIPE_DLY` cycles after its `hcount`/`vcount`.
- `rgb_o` out 9: registered colour to the scan converter. Forced to 0 while blanked.
- `hsync_o` out 1: delayed hsync, active-high.
- `vsync_o` out 1: delayed vsync, active-high.
- `hblank_o` out 1: delayed hblank, active-high.
- `vblank_o` out 1: delayed vblank, active-high.
- `irq_o` out 1: level interrupt to the CPU. Held until acknowledged.
- `irq_ack` in 1: single-cycle acknowledge; clears `irq_o`.
- `frame_o` out 1: one-cycle pulse at the start of vblank. Undelayed.

## Operation
- **Counters.**
  - `hcount` increments every cycle and wraps `H_TOTAL-1 -> 0`.
  - `vcount` increments only when `hcount==H_TOTAL-1`, and wraps `V_TOTAL-1 -> 0` on that same cycle.
  - Both counters are 9 bits; comparisons are unsigned.
- **Raw strobes**, decoded combinationally from the counters:
  - hblank = `hcount>=H_ACTIVE`.
  - vblank = `vcount>=V_ACTIVE`.
  - hsync = `H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_WIDTH`.
  - vsync = the same window applied to `vcount` with `V_SYNC_*`, covering entire lines.
- **Alignment.**
  - The four raw strobes pass through a shift register of depth `PIPE_DLY+1`.
  - `pix_i` is registered once into `rgb_o`. The register loads 0 when the delayed `hblank` or `vblank` (the depth-`PIPE_DLY` tap) is set.
  - Result: `rgb_o` and the four `*_o` strobes describe the same raster position.
- **irq.**
  - Set when `hcount==0` and `vcount[5:0]==IRQ_PHASE` and `vcount<V_TOTAL`. With defaults this gives lines 16, 80, 144 and 208: four per frame.
  - Cleared by `irq_ack`.
  - If set and ack occur in the same cycle, set wins.
  - An ack while `irq_o`=0 has no effect.
- **frame_o.** High for exactly the one cycle where `hcount==0` and `vcount==V_ACTIVE`.

## Timing
- **Reset values:** `hcount`=0, `vcount`=0, every delay stage 0, `rgb_o`=0, all `*_o` strobes 0, `irq_o`=0, `frame_o`=0.
- **After reset release:** the first cycle shows `hcount`=0. The delayed strobes reach valid values after `PIPE_DLY+1` cycles; during that window they read 0.
- **Alignment:** counter value at cycle t produces `pix_i` at t+`PIPE_DLY`, then `rgb_o` and the strobes at t+`PIPE_DLY`+1.
- **Reset mid-frame:** takes effect on the next edge. Counters and the pipeline return to 0, and a pending irq is dropped.
- **Frame period:** `H_TOTAL`*`V_TOTAL` = 100608 cycles.
- **Strobe pulse widths:**
  - hsync: `H_SYNC_WIDTH` cycles, once per line.
  - hblank: 128 cycles per line.
  - vblank: 22 lines, i.e. 8448 cycles.

## Structure
- **Package `centipede_video_pkg`:** default timing constants, the 9-bit RGB colour type, and a packed struct `{hs,vs,hb,vb}` for the strobe bundle.
- **Sub-module `video_delay_line`:** parameterised width and depth; a synchronous-reset shift register. It is instantiated once for the strobe bundle. Counters, decode, irq and `rgb_o` stay in the top level.

## Test plan
- **Reset, then free-run two frames:**
  - `hcount` wraps 383->0.
  - `vcount` wraps 261->0, and does so at `hcount`=383.
  - `frame_o` fires once, at `vcount`=240 `hcount`=0, with 100608 cycles between pulses.
- **Strobe widths:**
  - hsync high 32 cycles starting at delayed `hcount`=288.
  - hblank high 128 cycles per line.
  - vsync high 4 lines starting at line 246.
  - vblank high 22 lines.
- **Alignment** (`PIPE_DLY`=2; the bench models the renderer as `pix_i`=`{vcount[2:0],hcount[5:0]}` delayed 2 cycles):
  - `rgb_o` matches the expected value exactly 3 cycles after the counter value that produced it.
  - `rgb_o`=0 whenever `hblank_o`|`vblank_o`.
- **irq:**
  - Asserted at lines 16, 80, 144, 208.
  - With no ack it stays high across lines.
  - `irq_ack` at line 20 drops it in the next cycle.
  - Ack coincident with the line-80 set leaves `irq_o`=1.
- **Reset at line 100, `hcount` 150:** on the next cycle `hcount`=`vcount`=0, `irq_o`=0 and all `*_o`=0; the strobes resume valid after 3 cycles.
